// File: rtl/tilt_binner.sv
// =============================================================================
// Module   : tilt_binner
// Brief    : Quantises a signed sample into bins with hysteresis and debounce.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tilt_binner #(
    parameter int IN_W       = 10,
    parameter int NBINS      = 10,
    parameter int FIRST_EDGE = -80,
    parameter int BIN_W      = 20,
    parameter int HYST       = 4,
    parameter int STABLE_CNT = 3,
    parameter int RESET_BIN  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_data,
    output logic [$clog2(NBINS)-1:0] bin_idx,
    output logic [NBINS-1:0]         bin_onehot,
    output logic                     changed
);

    localparam int c_BW = $clog2(NBINS);
    localparam int c_CW = $clog2(STABLE_CNT + 1);
    localparam logic [NBINS-1:0] c_ONE = {{(NBINS-1){1'b0}}, 1'b1};
    localparam logic [c_BW-1:0]  c_RST_BIN = c_BW'(RESET_BIN);
    localparam logic [c_CW-1:0]  c_STABLE  = c_CW'(STABLE_CNT);

    if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
        $error("tilt_binner: IN_W must be in 2..32");
    end
    if (NBINS < 2 || NBINS > 32) begin : g_bad_nbins
        $error("tilt_binner: NBINS must be in 2..32");
    end
    if (BIN_W <= 0) begin : g_bad_bin_w
        $error("tilt_binner: BIN_W must be > 0");
    end
    if (HYST < 0 || HYST >= BIN_W) begin : g_bad_hyst
        $error("tilt_binner: HYST must satisfy 0 <= HYST < BIN_W");
    end
    if (STABLE_CNT < 1) begin : g_bad_stable
        $error("tilt_binner: STABLE_CNT must be >= 1");
    end
    if (RESET_BIN < 0 || RESET_BIN >= NBINS) begin : g_bad_reset_bin
        $error("tilt_binner: RESET_BIN must be < NBINS");
    end

    function automatic logic signed [31:0] edge_at(input int k);
        return 32'(FIRST_EDGE + k * BIN_W);
    endfunction

    logic signed [31:0] w_x;
    logic [c_BW-1:0]    w_raw;
    logic [c_BW-1:0]    w_cand;
    logic               w_lo_ok;
    logic               w_hi_ok;
    logic [c_CW-1:0]    w_next_cnt;

    logic [c_BW-1:0]    r_bin;
    logic [c_BW-1:0]    r_pend;
    logic [c_CW-1:0]    r_cnt;
    logic [NBINS-1:0]   r_onehot;
    logic               r_changed;

    assign w_x = 32'(in_data);

    always_comb begin
        w_raw   = c_BW'(NBINS - 1);
        w_lo_ok = 1'b1;
        w_hi_ok = 1'b1;
        // Descending scan leaves the smallest qualifying edge index in w_raw
        for (int k = NBINS - 2; k >= 0; k--) begin
            if (w_x <= edge_at(k)) begin
                w_raw = c_BW'(k);
            end
        end
        for (int k = 0; k < NBINS; k++) begin
            if (r_bin == c_BW'(k)) begin
                if (k > 0) begin
                    w_lo_ok = (w_x > (edge_at(k - 1) - HYST));
                end
                if (k < NBINS - 1) begin
                    w_hi_ok = (w_x <= (edge_at(k) + HYST));
                end
            end
        end
        w_cand = (w_lo_ok && w_hi_ok) ? r_bin : w_raw;
    end

    always_comb begin
        if (w_cand != r_pend) begin
            w_next_cnt = c_CW'(1);
        end else if (r_cnt >= c_STABLE) begin
            w_next_cnt = c_STABLE;
        end else begin
            w_next_cnt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= c_RST_BIN;
            r_pend    <= c_RST_BIN;
            r_cnt     <= '0;
            r_onehot  <= c_ONE << RESET_BIN;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (clear) begin
                r_bin    <= c_RST_BIN;
                r_pend   <= c_RST_BIN;
                r_cnt    <= '0;
                r_onehot <= c_ONE << RESET_BIN;
            end else if (in_valid) begin
                if (w_cand == r_bin) begin
                    r_cnt <= '0;
                end else begin
                    r_pend <= w_cand;
                    if (w_next_cnt == c_STABLE) begin
                        r_bin     <= w_cand;
                        r_onehot  <= c_ONE << w_cand;
                        r_cnt     <= '0;
                        r_changed <= 1'b1;
                    end else begin
                        r_cnt <= w_next_cnt;
                    end
                end
            end
        end
    end

    assign bin_idx    = r_bin;
    assign bin_onehot = r_onehot;
    assign changed    = r_changed;

endmodule

`default_nettype wire

// File: tb/tb_tilt_binner.sv
// =============================================================================
// Module   : tb_tilt_binner
// Brief    : Scoreboard bench for tilt_binner at default parameters.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_tilt_binner;

    localparam int IN_W  = 10;
    localparam int NBINS = 10;
    localparam int BW    = 4;

    logic                   clk      = 1'b0;
    logic                   rst_n    = 1'b1;
    logic                   clear    = 1'b0;
    logic                   in_valid = 1'b0;
    logic signed [IN_W-1:0] in_data  = '0;
    logic [BW-1:0]          bin_idx;
    logic [NBINS-1:0]       bin_onehot;
    logic                   changed;

    tilt_binner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .bin_idx    (bin_idx),
        .bin_onehot (bin_onehot),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               bin;
        logic [NBINS-1:0] oh;
        logic             chg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_bin   = 4;
    int   m_pend  = 4;
    int   m_cnt   = 0;

    // Closed-form raw bin: ceil((x - first_edge) / bin_width), clamped
    function automatic int ref_raw(input int x);
        int k;
        if (x <= -80) return 0;
        k = (x + 80 + 19) / 20;
        if (k > 9) k = 9;
        return k;
    endfunction

    function automatic bit ref_hold(input int c, input int x);
        bit lo_ok;
        bit hi_ok;
        lo_ok = (c == 0) || (x > (-80 + 20 * (c - 1) - 4));
        hi_ok = (c == 9) || (x <= (-80 + 20 * c + 4));
        return lo_ok && hi_ok;
    endfunction

    function automatic void model_reset();
        m_bin  = 4;
        m_pend = 4;
        m_cnt  = 0;
    endfunction

    task automatic step(input int x, input bit v, input bit clr);
        exp_t e;
        int   cand;
        @(negedge clk);
        in_data  = IN_W'(x);
        in_valid = v;
        clear    = clr;
        e.chg    = 1'b0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            cand = ref_hold(m_bin, x) ? m_bin : ref_raw(x);
            if (cand == m_bin) begin
                m_cnt = 0;
            end else begin
                if (cand != m_pend) begin
                    m_pend = cand;
                    m_cnt  = 1;
                end else if (m_cnt < 3) begin
                    m_cnt = m_cnt + 1;
                end
                if (m_cnt == 3) begin
                    m_bin = cand;
                    m_cnt = 0;
                    e.chg = 1'b1;
                end
            end
        end
        e.bin = m_bin;
        e.oh  = NBINS'(1) << m_bin;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (bin_idx !== 4'd4 || bin_onehot !== 10'h010 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: bin=%0d oh=%h chg=%b, want bin=4 oh=010 chg=0",
                     bin_idx, bin_onehot, changed);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bin_idx !== 4'd4 || bin_onehot !== 10'h010 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: bin=%0d oh=%h chg=%b, want bin=4 oh=010 chg=0",
                     bin_idx, bin_onehot, changed);
        end
    endtask

    task automatic test_commit();
        int   xs[4] = '{45, 45, 45, 0};
        bit   vs[4] = '{1, 1, 1, 0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step(xs[i], vs[i], 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL commit[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
        end
        n_tests++;
        if (bin_idx !== 4'd7 || bin_onehot !== 10'h080 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_final: bin=%0d oh=%h chg=%b, want bin=7 oh=080 chg=0",
                     bin_idx, bin_onehot, changed);
        end
    endtask

    task automatic test_hysteresis();
        int   xs[6] = '{38, 38, 38, 35, 35, 35};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            step(xs[i], 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL hyst[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
        end
        n_tests++;
        if (bin_idx !== 4'd6 || bin_onehot !== 10'h040) begin
            n_fail++;
            $display("FAIL hyst_final: bin=%0d oh=%h, want bin=6 oh=040", bin_idx, bin_onehot);
        end
    endtask

    task automatic test_extremes();
        int   xs[6] = '{-512, -512, -512, 511, 511, 511};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            step(xs[i], 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL extreme[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
            if (i == 2) begin
                n_tests++;
                if (bin_idx !== 4'd0 || bin_onehot !== 10'h001) begin
                    n_fail++;
                    $display("FAIL extreme_low: bin=%0d oh=%h, want bin=0 oh=001",
                             bin_idx, bin_onehot);
                end
            end
        end
        n_tests++;
        if (bin_idx !== 4'd9 || bin_onehot !== 10'h200) begin
            n_fail++;
            $display("FAIL extreme_high: bin=%0d oh=%h, want bin=9 oh=200", bin_idx, bin_onehot);
        end
    endtask

    task automatic test_gaps();
        int   xs[6] = '{45, 45, 0, 45, 45, 45};
        exp_t e;
        step(0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            step(xs[i], 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL gap[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
            // Idle cycle carries a far-off value that must be ignored
            step(-300, 1'b0, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || changed !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_idle[%0d]: bin=%0d chg=%b, want bin=%0d chg=0",
                         i, bin_idx, changed, e.bin);
            end
        end
        n_tests++;
        if (bin_idx !== 4'd7) begin
            n_fail++;
            $display("FAIL gap_final: bin=%0d, want bin=7", bin_idx);
        end
    endtask

    task automatic test_clear();
        int   xs[7] = '{45, 45, 0, 45, 45, 45, 0};
        bit   cs[7] = '{0, 0, 1, 0, 0, 0, 0};
        bit   vs[7] = '{1, 1, 1, 1, 1, 1, 0};
        exp_t e;
        step(0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            step(xs[i], vs[i], cs[i]);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL clear[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
            if (i == 2) begin
                n_tests++;
                if (bin_idx !== 4'd4 || changed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_now: bin=%0d chg=%b, want bin=4 chg=0", bin_idx, changed);
                end
            end
        end
        n_tests++;
        if (bin_idx !== 4'd7) begin
            n_fail++;
            $display("FAIL clear_final: bin=%0d, want bin=7", bin_idx);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        step(0, 1'b0, 1'b1);
        void'(sb.pop_front());
        step(45, 1'b1, 1'b0);
        void'(sb.pop_front());
        step(45, 1'b1, 1'b0);
        void'(sb.pop_front());
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(45, 1'b1, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
        end
        n_tests++;
        if (bin_idx !== 4'd7) begin
            n_fail++;
            $display("FAIL reset_mid_final: bin=%0d, want bin=7", bin_idx);
        end
    endtask

    task automatic test_back_to_back();
        int   x;
        bit   v;
        bit   c;
        exp_t e;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(0, 1023) - 512;
                1:       x = -80 + 20 * $urandom_range(0, 8) + $urandom_range(0, 10) - 5;
                default: x = -80 + 20 * (m_bin - 1) + $urandom_range(0, 40) - 8;
            endcase
            if (x < -512) x = -512;
            if (x > 511)  x = 511;
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 63) == 0);
            step(x, v, c);
            e = sb.pop_front();
            n_tests++;
            if (bin_idx !== BW'(e.bin) || bin_onehot !== e.oh || changed !== e.chg) begin
                n_fail++;
                $display("FAIL b2b[%0d] x=%0d v=%b c=%b: bin=%0d oh=%h chg=%b, want bin=%0d oh=%h chg=%b",
                         i, x, v, c, bin_idx, bin_onehot, changed, e.bin, e.oh, e.chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hysteresis();
        test_extremes();
        test_gaps();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tilt_binner.md
TILT_BINNER -- requirements
Module: tilt_binner

Interface
REQ-001 Parameter IN_W, default 10: width of the signed two's-complement input sample.
REQ-002 Parameter NBINS, default 10: number of output bins; legal range 2..32.
REQ-003 Parameter FIRST_EDGE, default -80: signed upper edge of bin 0.
REQ-004 Parameter BIN_W, default 20: bin width in LSBs; must be greater than 0.
REQ-005 Parameter HYST, default 4: hysteresis margin in LSBs; 0 <= HYST < BIN_W.
REQ-006 Parameter STABLE_CNT, default 3: consecutive qualifying samples required to commit a bin change; must be at least 1.
REQ-007 Parameter RESET_BIN, default 4: bin index after reset or clear; must be less than NBINS.
REQ-008 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-009 clk, input, 1: rising-edge clock.
REQ-010 rst_n, input, 1: asynchronous active-low reset.
REQ-011 clear, input, 1: synchronous return to RESET_BIN.
REQ-012 in_valid, input, 1: in_data is qualified this cycle.
REQ-013 in_data, input, IN_W: signed sample (e.g. accelerometer axis).
REQ-014 bin_idx, output, clog2(NBINS): committed bin index, registered.
REQ-015 bin_onehot, output, NBINS: bit bin_idx set, all other bits 0, registered.
REQ-016 changed, output, 1: one-cycle pulse on the cycle after a commit.

Function
REQ-017 Edges SHALL be T_k = FIRST_EDGE + k*BIN_W for k = 0..NBINS-2, computed as 32-bit signed elaboration constants.
REQ-018 All comparisons SHALL be signed, with in_data sign-extended to 32 bits.
REQ-019 The raw bin SHALL be the smallest k with in_data <= T_k, or NBINS-1 if no such k exists.
REQ-020 The hold window for current bin c SHALL be (T_{c-1} - HYST, T_c + HYST].
  - For c = 0, the window has no lower bound.
  - For c = NBINS-1, the window has no upper bound.
REQ-021 Candidate bin selection:
  - Candidate = c if in_data lies inside the hold window.
  - Otherwise candidate = raw bin.
REQ-022 State SHALL update only on edges where in_valid = 1; when in_valid = 0, all state holds and changed = 0.
REQ-023 If candidate == c, the debounce counter SHALL be cleared to 0.
REQ-024 If candidate != c and candidate != pending:
  - pending <= candidate.
  - count <= 1.
REQ-025 If candidate != c and candidate == pending, count SHALL increment, saturating at STABLE_CNT.
REQ-026 Commit occurs when the updated count reaches STABLE_CNT, on the same edge:
  - bin_idx and bin_onehot <= candidate.
  - count <= 0.
  - changed <= 1.
REQ-027 With STABLE_CNT = 1, the commit SHALL occur on the first qualifying sample.
REQ-028 Latency: outputs SHALL reflect a commit one clock edge after the committing in_valid sample; no combinational path from in_data to any output.
REQ-029 changed SHALL be 1 for exactly one cycle per commit and 0 otherwise.
REQ-030 clear = 1 SHALL take priority over in_valid:
  - bin_idx <= RESET_BIN, pending <= RESET_BIN, count <= 0.
  - changed <= 0.
REQ-031 Inputs at the extremes (-2^(IN_W-1), 2^(IN_W-1)-1) SHALL map without overflow to bin 0 and bin NBINS-1 respectively.
REQ-032 Illegal parameter combinations SHALL stop elaboration with an error.

Reset
REQ-033 While rst_n = 0, asynchronously:
  - bin_idx = RESET_BIN, bin_onehot = 1 << RESET_BIN, changed = 0.
  - pending = RESET_BIN, count = 0.
REQ-034 Reset asserted mid-debounce SHALL discard pending progress; the first valid sample after release SHALL start counting from 1.

Verification (default parameters)
REQ-035 Reset release -> bin_idx = 4, bin_onehot = 0x010, changed = 0.
REQ-036 Three valid samples of +45 -> bin_idx = 4 after samples 1 and 2.
  - After sample 3: bin_idx = 7, bin_onehot = 0x080.
  - changed = 1 for one cycle only.
REQ-037 From bin 7, three samples of +38 -> stays 7 (inside the hold window, 38 > 36).
  - Then three samples of +35 -> bin 6, bin_onehot = 0x040.
REQ-038 Three samples of -512 -> bin 0 (0x001), never bin 9.
  - Then three samples of +511 -> bin 9 (0x200).
REQ-039 From bin 4, sequence 45, 45, 0, 45, 45, 45 with in_valid gaps between samples:
  - No commit before the sixth sample.
  - Commit to bin 7 on the sixth sample.
REQ-040 clear pulsed after two samples of +45 -> bin_idx = 4, changed = 0.
  - A subsequent three samples of +45 are needed to reach bin 7.
